// File: rtl/array_mult_sequencer_pkg.sv
// Shared constants and state encoding for the digit-serial multiply sequencer.
package array_mult_sequencer_pkg;

  localparam int DIGIT_W = 4;
  localparam int PP_W    = 8;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

endpackage

// File: rtl/array_mult_sequencer_core.sv
// 4x4 -> 8 unsigned array multiplier: one shifted AND row per multiplier bit.
module ArrayMultiplier4Bit (
  input  logic [3:0] a,
  input  logic [3:0] b,
  output logic [7:0] p
);

  always_comb begin
    p = '0;
    for (int k = 0; k < 4; k++) begin
      if (b[k]) p = p + ({4'b0000, a} << k);
    end
  end

endmodule

// File: rtl/array_mult_sequencer.sv
// Multi-cycle WIDTH x WIDTH unsigned multiplier reusing one 4x4 array core,
// one digit pair per cycle, accumulating shifted partial products.
module array_mult_sequencer
  import array_mult_sequencer_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic               busy,
  output logic               done,
  output logic [2*WIDTH-1:0] product
);

  localparam int N     = WIDTH / DIGIT_W;
  localparam int PW    = 2 * WIDTH;
  localparam int CNT_W = (N > 1) ? $clog2(N) : 1;

  if ((WIDTH % DIGIT_W) != 0 || WIDTH < DIGIT_W) begin : g_bad_width
    $error("array_mult_sequencer: WIDTH must be a multiple of 4 and >= 4");
  end

  // State is kept as a named internal signal so checkers can bind to it.
  state_t             state, state_nxt;
  logic [WIDTH-1:0]   a_r, b_r;
  logic [PW-1:0]      acc, pp_sh;
  logic [CNT_W-1:0]   i_cnt, j_cnt;
  logic [DIGIT_W-1:0] a_dig, b_dig;
  logic [PP_W-1:0]    pp;
  logic               last;

  assign a_dig = a_r[DIGIT_W*int'(i_cnt) +: DIGIT_W];
  assign b_dig = b_r[DIGIT_W*int'(j_cnt) +: DIGIT_W];
  assign last  = (i_cnt == CNT_W'(N-1)) && (j_cnt == CNT_W'(N-1));
  assign pp_sh = PW'(pp) << (DIGIT_W * (int'(i_cnt) + int'(j_cnt)));

  ArrayMultiplier4Bit u_core (
    .a (a_dig),
    .b (b_dig),
    .p (pp)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: if (start) state_nxt = ST_RUN;
      ST_RUN:  if (last)  state_nxt = ST_DONE;
      ST_DONE: state_nxt = ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    busy = (state != ST_IDLE);
    done = (state == ST_DONE);
  end

  // j is the inner digit loop; i advances when j wraps.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_r     <= '0;
      b_r     <= '0;
      acc     <= '0;
      i_cnt   <= '0;
      j_cnt   <= '0;
      product <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (start) begin
            a_r   <= a;
            b_r   <= b;
            acc   <= '0;
            i_cnt <= '0;
            j_cnt <= '0;
          end
        end
        ST_RUN: begin
          acc <= acc + pp_sh;
          if (last) begin
            product <= acc + pp_sh;
            i_cnt   <= '0;
            j_cnt   <= '0;
          end else if (j_cnt == CNT_W'(N-1)) begin
            j_cnt <= '0;
            i_cnt <= i_cnt + 1'b1;
          end else begin
            j_cnt <= j_cnt + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_array_mult_sequencer.sv
// Directed bench for array_mult_sequencer at WIDTH=8, 16 and 4.
module tb_array_mult_sequencer;

  logic clk = 1'b0;
  logic rst = 1'b0;

  logic        start8 = 1'b0;
  logic [7:0]  a8 = '0, b8 = '0;
  logic        busy8, done8;
  logic [15:0] product8;

  logic        start16 = 1'b0;
  logic [15:0] a16 = '0, b16 = '0;
  logic        busy16, done16;
  logic [31:0] product16;

  logic        start4 = 1'b0;
  logic [3:0]  a4 = '0, b4 = '0;
  logic        busy4, done4;
  logic [7:0]  product4;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  array_mult_sequencer #(.WIDTH(8)) dut8 (
    .clk(clk), .rst(rst), .start(start8), .a(a8), .b(b8),
    .busy(busy8), .done(done8), .product(product8)
  );

  array_mult_sequencer #(.WIDTH(16)) dut16 (
    .clk(clk), .rst(rst), .start(start16), .a(a16), .b(b16),
    .busy(busy16), .done(done16), .product(product16)
  );

  array_mult_sequencer #(.WIDTH(4)) dut4 (
    .clk(clk), .rst(rst), .start(start4), .a(a4), .b(b4),
    .busy(busy4), .done(done4), .product(product4)
  );

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    n_checks++;
    if ({busy8, done8, busy16, done16, busy4, done4} !== 6'b0) begin
      n_fail++;
      $display("FAIL reset_flags: busy/done = %b, expected 000000",
               {busy8, done8, busy16, done16, busy4, done4});
    end
    n_checks++;
    if (product8 !== 16'h0 || product16 !== 32'h0 || product4 !== 8'h0) begin
      n_fail++;
      $display("FAIL reset_product: got %h %h %h, expected 0 0 0",
               product8, product16, product4);
    end
    rst = 1'b0;
    @(posedge clk);
    #1;
  endtask

  // Runs one WIDTH=8 operation and checks latency, pulse width and result.
  task automatic run8(input logic [7:0] av, input logic [7:0] bv,
                      input logic [15:0] exp_p, input logic [15:0] hold_p,
                      input string name);
    a8 = av; b8 = bv; start8 = 1'b1;
    @(posedge clk);
    #1;
    start8 = 1'b0;
    n_checks++;
    if (busy8 !== 1'b1 || done8 !== 1'b0) begin
      n_fail++;
      $display("FAIL %s_accept: busy=%b done=%b, expected busy=1 done=0", name, busy8, done8);
    end
    for (int k = 1; k <= 4; k++) begin
      @(posedge clk);
      #1;
      if (k < 4) begin
        n_checks++;
        if (done8 !== 1'b0 || product8 !== hold_p) begin
          n_fail++;
          $display("FAIL %s_run%0d: done=%b product=%h, expected done=0 product=%h",
                   name, k, done8, product8, hold_p);
        end
      end else begin
        n_checks++;
        if (done8 !== 1'b1 || busy8 !== 1'b1 || product8 !== exp_p) begin
          n_fail++;
          $display("FAIL %s_done: done=%b busy=%b product=%h, expected done=1 busy=1 product=%h",
                   name, done8, busy8, product8, exp_p);
        end
      end
    end
    @(posedge clk);
    #1;
    n_checks++;
    if (busy8 !== 1'b0 || done8 !== 1'b0 || product8 !== exp_p) begin
      n_fail++;
      $display("FAIL %s_after: busy=%b done=%b product=%h, expected busy=0 done=0 product=%h",
               name, busy8, done8, product8, exp_p);
    end
  endtask

  task automatic test_basic();
    run8(8'h12, 8'h34, 16'h03A8, 16'h0000, "basic");
  endtask

  task automatic test_back_to_back();
    run8(8'hFF, 8'hFF, 16'hFE01, 16'h03A8, "ffxff");
    run8(8'hAB, 8'hCD, 16'h88EF, 16'hFE01, "abxcd");
  endtask

  task automatic test_start_ignored();
    int n_done;
    n_done = 0;
    a8 = 8'h0F; b8 = 8'h0F; start8 = 1'b1;
    @(posedge clk);
    #1;
    a8 = 8'hFF; b8 = 8'hFF;
    for (int k = 1; k <= 10; k++) begin
      @(posedge clk);
      #1;
      if (k == 3) start8 = 1'b0;
      if (done8 === 1'b1) begin
        n_done++;
        n_checks++;
        if (k != 4 || product8 !== 16'h00E1) begin
          n_fail++;
          $display("FAIL ignore_done: done at cycle %0d product=%h, expected cycle 4 product=00e1",
                   k, product8);
        end
      end
      if (k >= 6) begin
        n_checks++;
        if (busy8 !== 1'b0) begin
          n_fail++;
          $display("FAIL ignore_idle%0d: busy=%b, expected 0", k, busy8);
        end
      end
    end
    n_checks++;
    if (n_done != 1) begin
      n_fail++;
      $display("FAIL ignore_count: %0d done pulses, expected 1", n_done);
    end
  endtask

  task automatic test_async_reset();
    int n_done;
    n_done = 0;
    a8 = 8'h80; b8 = 8'h80; start8 = 1'b1;
    @(posedge clk);
    #1;
    start8 = 1'b0;
    repeat (2) @(posedge clk);
    #3;
    rst = 1'b1;
    #1;
    n_checks++;
    if (busy8 !== 1'b0 || done8 !== 1'b0 || product8 !== 16'h0) begin
      n_fail++;
      $display("FAIL async_rst: busy=%b done=%b product=%h, expected 0 0 0000",
               busy8, done8, product8);
    end
    @(posedge clk);
    #2;
    rst = 1'b0;
    for (int k = 0; k < 6; k++) begin
      @(posedge clk);
      #1;
      if (done8 === 1'b1 || busy8 === 1'b1) n_done++;
    end
    n_checks++;
    if (n_done != 0) begin
      n_fail++;
      $display("FAIL async_no_done: %0d busy/done cycles after reset, expected 0", n_done);
    end
    run8(8'h08, 8'h08, 16'h0040, 16'h0000, "post_rst");
  endtask

  task automatic run16(input logic [15:0] av, input logic [15:0] bv,
                       input logic [31:0] exp_p, input logic [31:0] hold_p,
                       input string name);
    a16 = av; b16 = bv; start16 = 1'b1;
    @(posedge clk);
    #1;
    start16 = 1'b0;
    for (int k = 1; k <= 16; k++) begin
      @(posedge clk);
      #1;
      if (k < 16) begin
        if (done16 !== 1'b0 || product16 !== hold_p) begin
          n_checks++;
          n_fail++;
          $display("FAIL %s_run%0d: done=%b product=%h, expected done=0 product=%h",
                   name, k, done16, product16, hold_p);
        end
      end else begin
        n_checks++;
        if (done16 !== 1'b1 || product16 !== exp_p) begin
          n_fail++;
          $display("FAIL %s_done: done=%b product=%h, expected done=1 product=%h",
                   name, done16, product16, exp_p);
        end
      end
    end
    @(posedge clk);
    #1;
    n_checks++;
    if (busy16 !== 1'b0 || done16 !== 1'b0) begin
      n_fail++;
      $display("FAIL %s_after: busy=%b done=%b, expected 0 0", name, busy16, done16);
    end
  endtask

  task automatic test_width16();
    run16(16'hFFFF, 16'hFFFF, 32'hFFFE0001, 32'h0, "w16_max");
    run16(16'h0000, 16'hFFFF, 32'h0, 32'hFFFE0001, "w16_zero");
  endtask

  task automatic test_width4_exhaustive();
    int bad;
    logic [7:0] exp_p;
    bad = 0;
    start4 = 1'b1;
    for (int x = 0; x < 16; x++) begin
      for (int y = 0; y < 16; y++) begin
        a4 = 4'(x); b4 = 4'(y);
        exp_p = 8'(x * y);
        @(posedge clk);
        #1;
        a4 = ~a4; b4 = ~b4;
        if (busy4 !== 1'b1 || done4 !== 1'b0) bad++;
        @(posedge clk);
        #1;
        if (done4 !== 1'b1 || product4 !== exp_p) begin
          bad++;
          if (bad < 5)
            $display("FAIL w4_%0dx%0d: done=%b product=%h, expected done=1 product=%h",
                     x, y, done4, product4, exp_p);
        end
        @(posedge clk);
        #1;
        if (busy4 !== 1'b0 || done4 !== 1'b0) bad++;
      end
    end
    start4 = 1'b0;
    n_checks++;
    if (bad != 0) begin
      n_fail++;
      $display("FAIL w4_exhaustive: %0d bad cycles, expected 0", bad);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_back_to_back();
    test_start_ignored();
    test_async_reset();
    test_width16();
    test_width4_exhaustive();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
